// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8-entry general-purpose register file, r0 hardwired to zero.
// Two combinational read ports; one write port addressed by srcA.
module reg_file_8x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic [DATA_W-1:0] writeValue,
  output logic [DATA_W-1:0] ReadA,
  output logic [DATA_W-1:0] ReadB
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_rf [DEPTH];

  // r0 has no storage at all; the zero is a constant, so writes to it vanish.
  assign w_rf[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    logic              w_we;

    assign w_we = RegWrite && (srcA == ADDR_W'(i));

    // Register i: cleared by reset, loads writeValue when addressed.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_q <= '0;
      end else if (w_we) begin
        r_q <= writeValue;
      end
    end

    assign w_rf[i] = r_q;
  end

  // Read ports: plain muxes on stored contents, no write-through path.
  always_comb begin
    ReadA = w_rf[srcA];
    ReadB = w_rf[srcB];
  end

endmodule

// File: tb/tb_reg_file_8x16.sv
// tb_reg_file_8x16: randomized + directed bench for reg_file_8x16.
// Reference model is a plain array updated by the architectural write rule.
module tb_reg_file_8x16;

  logic        CLK;
  logic        RST_N;
  logic        RegWrite;
  logic [2:0]  srcA;
  logic [2:0]  srcB;
  logic [15:0] writeValue;
  logic [15:0] ReadA;
  logic [15:0] ReadB;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mdl [8];

  reg_file_8x16 dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RegWrite   (RegWrite),
    .srcA       (srcA),
    .srcB       (srcB),
    .writeValue (writeValue),
    .ReadA      (ReadA),
    .ReadB      (ReadB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
  endfunction

  // One write/read cycle, entered just after a falling edge.
  task automatic step(input logic we, input logic [2:0] a,
                      input logic [2:0] b, input logic [15:0] d);
    RegWrite = we; srcA = a; srcB = b; writeValue = d;
    #1;
    check("pre_edge_A", ReadA, mdl[a]);
    check("pre_edge_B", ReadB, mdl[b]);
    @(posedge CLK);
    if (we && RST_N && a != 3'd0) mdl[a] = d;
    @(negedge CLK);
    #1;
    check("post_edge_A", ReadA, mdl[a]);
    check("post_edge_B", ReadB, mdl[b]);
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      srcA = 3'(i); srcB = 3'(7 - i);
      #1;
      check({tag, "_A"}, ReadA, 16'h0000);
      check({tag, "_B"}, ReadB, 16'h0000);
    end
  endtask

  initial begin
    RST_N = 1'b0; RegWrite = 1'b0;
    srcA = '0; srcB = '0; writeValue = '0;
    mdl_clear();
    repeat (2) @(negedge CLK);
    sweep_zero("reset_init");
    RST_N = 1'b1;
    @(negedge CLK);

    // Populate, then async reset in the middle of a low phase.
    for (int i = 1; i < 8; i++) step(1'b1, 3'(i), 3'(i), 16'(32'h1111 * i));
    #2;
    RST_N = 1'b0;
    mdl_clear();
    sweep_zero("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Fill 0..7 with their index.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 3'(i), 16'(i));
    RegWrite = 1'b0;
    for (int k = 0; k < 4; k++) begin
      srcA = 3'(2 * k); srcB = 3'(2 * k + 1);
      #1;
      check("fill_A", ReadA, 16'(2 * k));
      check("fill_B", ReadB, 16'(2 * k + 1));
    end
    @(negedge CLK);

    // Zero register ignores writes.
    step(1'b1, 3'd0, 3'd0, 16'hFFFF);
    check("r0_A", ReadA, 16'h0000);
    check("r0_B", ReadB, 16'h0000);

    // Write disabled across several edges.
    RegWrite = 1'b0; srcA = 3'd2; srcB = 3'd2; writeValue = 16'hABCD;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("wr_disable", ReadA, 16'h0002);

    // No bypass: old value before the edge, new value after.
    RegWrite = 1'b1; srcA = 3'd5; srcB = 3'd5; writeValue = 16'h1234;
    #1;
    check("nobyp_pre_A", ReadA, 16'h0005);
    check("nobyp_pre_B", ReadB, 16'h0005);
    @(posedge CLK);
    mdl[5] = 16'h1234;
    @(negedge CLK);
    check("nobyp_post_A", ReadA, 16'h1234);
    check("nobyp_post_B", ReadB, 16'h1234);

    // Reset held across an edge with a write pending.
    RegWrite = 1'b1; srcA = 3'd3; srcB = 3'd3; writeValue = 16'h5555;
    RST_N = 1'b0;
    mdl_clear();
    @(posedge CLK);
    @(negedge CLK);
    RegWrite = 1'b1; srcA = 3'd3; writeValue = 16'h5555;
    sweep_zero("reset_mid_wr");
    RegWrite = 1'b0;
    RST_N = 1'b1;
    step(1'b1, 3'd3, 3'd3, 16'h00AA);
    check("after_reset_r3", ReadA, 16'h00AA);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
